// File: rtl/updi_link.sv
// UPDI link-layer sequencer: sends SYNC ahead of each command frame, checks the
// single-wire echo of every byte, then collects the expected response bytes.
module updi_link #(
    parameter logic [7:0]  SYNC_BYTE      = 8'h55,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned RSP_W          = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    input  logic             tx_last,
    input  logic [RSP_W-1:0] rsp_count,
    output logic             tx_ready,
    output logic [7:0]       rsp_data,
    output logic             rsp_valid,
    output logic             done,
    output logic             err_echo,
    output logic             err_rx,
    output logic             err_timeout,
    output logic [7:0]       uart_tx_data,
    output logic             uart_transmit_start,
    input  logic             uart_transmit_ready,
    input  logic [7:0]       uart_rx_data,
    input  logic             uart_rx_data_valid,
    input  logic             uart_rx_error
);

    localparam int unsigned   TMR_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_LOAD, S_ECHO, S_RECV, S_DRAIN, S_FIN
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       expected_q, expected_d;
    logic             last_q, last_d;
    logic [RSP_W-1:0] remain_q, remain_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             err_echo_q, err_echo_d;
    logic             err_rx_q, err_rx_d;
    logic             err_timeout_q, err_timeout_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       txd_q;
    logic             rx_valid_q;

    logic   rx_event;
    logic   timeout;
    logic   can_send;
    state_e fail_next;

    assign rx_event  = uart_rx_data_valid & ~rx_valid_q;
    assign timeout   = (tmr_q == TMR_LAST);
    // A start pulse must never escape during the reset cycle itself.
    assign can_send  = uart_transmit_ready & ~rst;
    // When the failing byte already closed the frame there is nothing left to drain.
    assign fail_next = last_q ? S_FIN : S_DRAIN;

    // NOTE: every output and next-state value gets a default first so no path infers a latch.
    always_comb begin
        state_d             = state_q;
        expected_d          = expected_q;
        last_d              = last_q;
        remain_d            = remain_q;
        tmr_d               = '0;
        err_echo_d          = err_echo_q;
        err_rx_d            = err_rx_q;
        err_timeout_d       = err_timeout_q;
        rsp_data_d          = rsp_data_q;
        rsp_valid_d         = 1'b0;
        tx_ready            = 1'b0;
        uart_transmit_start = 1'b0;
        uart_tx_data        = txd_q;
        done                = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    remain_d      = rsp_count;
                    err_echo_d    = 1'b0;
                    err_rx_d      = 1'b0;
                    err_timeout_d = 1'b0;
                    state_d       = S_SYNC;
                end
            end
            S_SYNC: begin
                if (can_send) begin
                    uart_tx_data        = SYNC_BYTE;
                    uart_transmit_start = 1'b1;
                    expected_d          = SYNC_BYTE;
                    last_d              = 1'b0;
                    state_d             = S_ECHO;
                end
            end
            S_LOAD: begin
                tx_ready = can_send;
                if (tx_valid && can_send) begin
                    uart_tx_data        = tx_data;
                    uart_transmit_start = 1'b1;
                    expected_d          = tx_data;
                    last_d              = tx_last;
                    state_d             = S_ECHO;
                end
            end
            S_ECHO: begin
                if (rx_event) begin
                    if (uart_rx_error) begin
                        err_rx_d = 1'b1;
                        state_d  = fail_next;
                    end else if (uart_rx_data != expected_q) begin
                        err_echo_d = 1'b1;
                        state_d    = fail_next;
                    end else if (!last_q) begin
                        state_d = S_LOAD;
                    end else if (remain_q == '0) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_RECV;
                    end
                end else if (timeout) begin
                    err_timeout_d = 1'b1;
                    state_d       = fail_next;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_RECV: begin
                if (rx_event) begin
                    if (uart_rx_error) begin
                        err_rx_d = 1'b1;
                        state_d  = S_FIN;
                    end else begin
                        rsp_data_d  = uart_rx_data;
                        rsp_valid_d = 1'b1;
                        remain_d    = remain_q - RSP_W'(1);
                        if (remain_q == RSP_W'(1)) state_d = S_FIN;
                    end
                end else if (timeout) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_FIN;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_DRAIN: begin
                tx_ready = 1'b1;
                if (tx_valid && tx_last) state_d = S_FIN;
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            expected_q    <= '0;
            last_q        <= 1'b0;
            remain_q      <= '0;
            tmr_q         <= '0;
            err_echo_q    <= 1'b0;
            err_rx_q      <= 1'b0;
            err_timeout_q <= 1'b0;
            rsp_data_q    <= '0;
            rsp_valid_q   <= 1'b0;
            txd_q         <= '0;
            rx_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            expected_q    <= expected_d;
            last_q        <= last_d;
            remain_q      <= remain_d;
            tmr_q         <= tmr_d;
            err_echo_q    <= err_echo_d;
            err_rx_q      <= err_rx_d;
            err_timeout_q <= err_timeout_d;
            rsp_data_q    <= rsp_data_d;
            rsp_valid_q   <= rsp_valid_d;
            txd_q         <= uart_tx_data;
            rx_valid_q    <= uart_rx_data_valid;
        end
    end

    assign rsp_data    = rsp_data_q;
    assign rsp_valid   = rsp_valid_q;
    assign err_echo    = err_echo_q;
    assign err_rx      = err_rx_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: doc/updi_link.md
Name: updi_link

Overview:
- Half-duplex UPDI link-layer sequencer sitting directly upstream of the uart block on the shared single-wire line.
- Takes a command frame as a byte stream from the programmer core and prefixes it with the SYNC character.
- Drives the uart transmitter byte by byte, checks that every transmitted byte echoes back on the receiver, then collects a fixed number of response bytes.
- Reports completion or error per frame.

Parameters:
- SYNC_BYTE, 8'h55, character sent before the first command byte of every frame.
- TIMEOUT_CYCLES, 4096, maximum idle clocks allowed while waiting for an echo or response byte.
- RSP_W, 4, width of rsp_count; a frame may expect up to 2^RSP_W-1 response bytes.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- tx_data  in  8  command byte from the host.
- tx_valid  in  1  tx_data valid.
- tx_last  in  1  marks the final command byte of the frame; qualified by tx_valid.
- rsp_count  in  RSP_W  number of response bytes expected; sampled with the first command byte.
- tx_ready  out  1  block accepts tx_data this cycle.
- rsp_data  out  8  received response byte.
- rsp_valid  out  1  one-cycle strobe; rsp_data valid.
- done  out  1  one-cycle strobe at the end of the frame (success or error).
- err_echo  out  1  level, valid with done: echo mismatch.
- err_rx  out  1  level, valid with done: uart rx_error seen.
- err_timeout  out  1  level, valid with done: timeout expired.
- uart_tx_data  out  8  to uart tx_data.
- uart_transmit_start  out  1  to uart transmit_start.
- uart_transmit_ready  in  1  from uart transmit_ready.
- uart_rx_data  in  8  from uart rx_data.
- uart_rx_data_valid  in  1  from uart rx_data_valid.
- uart_rx_error  in  1  from uart rx_error.

Behaviour:
- Reset: state IDLE; all outputs 0, except uart_tx_data 8'h00; error flags 0; counters 0.
- Received-byte event = 0->1 transition of uart_rx_data_valid, detected with a registered previous value. uart_rx_error is sampled at that event.
- IDLE: tx_ready=0. When tx_valid=1, latch rsp_count and go to SYNC. The byte is not consumed yet.
- SYNC: when uart_transmit_ready=1, drive uart_tx_data=SYNC_BYTE and pulse uart_transmit_start for 1 cycle, set expected=SYNC_BYTE, then go to ECHO.
- LOAD: tx_ready = uart_transmit_ready.
  - On tx_valid&tx_ready, in the same cycle: uart_tx_data=tx_data, uart_transmit_start=1, expected=tx_data, last_flag=tx_last.
  - Then go to ECHO.
- ECHO: timeout counter runs, cleared on entry.
  - On received-byte event with uart_rx_error=1: set err_rx, go to DRAIN.
  - On event with data != expected: set err_echo, go to DRAIN.
  - On a good echo:
    - SYNC echo -> LOAD.
    - Non-last byte -> LOAD.
    - Last byte with rsp_count=0 -> FIN.
    - Last byte with rsp_count>0 -> RECV.
  - Counter reaching TIMEOUT_CYCLES: set err_timeout, go to DRAIN.
- RECV: timeout counter cleared on entry and after each byte.
  - On each good event: rsp_data=uart_rx_data, rsp_valid=1 for 1 cycle, decrement remaining.
  - When remaining reaches 0 -> FIN.
  - rx_error or timeout: set the flag, go to FIN. Partial response bytes already delivered stay delivered.
- DRAIN: tx_ready=1. Accept and discard command bytes until a byte with tx_last=1 is accepted, then go to FIN.
  - If the failing byte was itself last (last_flag=1), go directly to FIN.
- FIN: done=1 for 1 cycle, error flags held. Go to IDLE.
  - Error flags clear when the next frame leaves IDLE.
- Only one error flag is ever set per frame: the first detected.
- Echo events arriving in LOAD, SYNC or IDLE are ignored and do not set errors.
- Single-byte frame (first byte has tx_last=1): SYNC, byte, echo; response handling as above.
- rsp_count is ignored after it is sampled; changes mid-frame have no effect.
- Reset mid-frame returns to IDLE immediately, drops uart_transmit_start, and emits no done.
- Throughput: one byte in flight at a time. The next byte is never started before the previous echo is validated.

Test Plan:
- Loopback uart, frame {8'h80 last}, rsp_count=1, inject response 8'h30 -> uart sees 0x55, 0x80; one rsp_valid with 8'h30; done with all flags 0.
- Frame {8'h04, 8'h12, 8'hAB last}, rsp_count=0, loopback -> three bytes after 0x55 in order; done one cycle after the 0xAB echo; rsp_valid never asserted.
- Frame of 3 bytes, corrupt the echo of byte 2 (0x12 -> 0x13) -> err_echo=1; byte 3 accepted via tx_ready and not transmitted; one done pulse.
- Echo never returns after SYNC -> err_timeout with done exactly TIMEOUT_CYCLES cycles after ECHO entry; uart_transmit_start not pulsed again.
- rsp_count=2, first response byte has uart_rx_error=1 -> err_rx=1, no rsp_valid, done.
- Assert rst during RECV after 1 of 3 response bytes -> next cycle all outputs 0, state IDLE; a following clean frame completes normally.
